// File: rtl/fir_pkg.sv
// ============================================================================
// Module   : fir_pkg
// Brief    : Shared filter geometry and feeder state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fir_pkg;

    localparam int TAPS        = 16;
    localparam int FIRE_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_FIRE  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } feeder_state_e;

    // Bits needed to hold the values 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that stops at LIMIT; clr and inc together yields 1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 5,
    parameter int LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_base;

    always_comb begin
        cnt_base = clr_i ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (inc_i && (cnt_base != WIDTH'(LIMIT))) begin
            cnt_d = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/fir_feeder.sv
// ============================================================================
// Module   : fir_feeder
// Brief    : Feeds coefficients/samples into a FIR filter and returns results.
//            Optional WAIT timeout enabled by macro FIR_FEEDER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fir_feeder #(
    parameter int TAPS        = fir_pkg::TAPS,
    parameter int FIRE_CYCLES = fir_pkg::FIRE_CYCLES,
    parameter int TIMEOUT     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic        s_is_coef,
    output logic        fir_wind,
    output logic        fir_load,
    output logic        fir_in_valid,
    output logic [15:0] fir_data,
    input  logic        fir_out_valid,
    input  logic [15:0] fir_out,
    output logic        m_valid,
    output logic [15:0] m_data,
    input  logic        m_ready,
    output logic        coef_ok,
    output logic        err
);

    import fir_pkg::*;

    localparam int CW = cnt_width(TAPS);
    localparam int FW = cnt_width(FIRE_CYCLES);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_SHIFT = ST_SHIFT;
    localparam logic [2:0] S_FIRE  = ST_FIRE;
    localparam logic [2:0] S_WAIT  = ST_WAIT;
    localparam logic [2:0] S_OUT   = ST_OUT;

    logic [2:0]    state_q, state_d;
    logic          s_ready_q, s_ready_d;
    logic          fir_wind_q, fir_wind_d;
    logic          fir_load_q, fir_load_d;
    logic          fir_in_valid_q, fir_in_valid_d;
    logic [15:0]   fir_data_q, fir_data_d;
    logic [FW-1:0] fire_cnt_q, fire_cnt_d;
    logic          m_valid_q, m_valid_d;
    logic [15:0]   m_data_q, m_data_d;
    logic [CW-1:0] coef_cnt, samp_cnt;
    logic          accept;
    logic          restart;

    assign accept  = s_valid && s_ready_q;
    // A coefficient arriving on a complete set starts a fresh set and window.
    assign restart = accept && s_is_coef && coef_ok;
    assign coef_ok = (coef_cnt == CW'(TAPS));

    sat_counter #(.WIDTH(CW), .LIMIT(TAPS)) u_coef_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (accept && s_is_coef),
        .clr_i (restart),
        .cnt_o (coef_cnt)
    );

    sat_counter #(.WIDTH(CW), .LIMIT(TAPS)) u_samp_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (accept && !s_is_coef),
        .clr_i (restart),
        .cnt_o (samp_cnt)
    );

`ifdef FIR_FEEDER_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT);
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    always_comb begin
        state_d        = state_q;
        fir_wind_d     = 1'b0;
        fir_load_d     = 1'b0;
        fir_data_d     = '0;
        fir_in_valid_d = 1'b0;
        fire_cnt_d     = fire_cnt_q;
        m_valid_d      = m_valid_q;
        m_data_d       = m_data_q;
`ifdef FIR_FEEDER_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
        err_d          = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    fir_data_d = s_data;
                    fir_wind_d = s_is_coef;
                    fir_load_d = !s_is_coef;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (fir_load_q && (samp_cnt == CW'(TAPS)) && coef_ok) begin
                    state_d        = S_FIRE;
                    fir_in_valid_d = 1'b1;
                    fire_cnt_d     = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FIRE: begin
                if (fire_cnt_q == FW'(FIRE_CYCLES - 1)) begin
                    state_d = S_WAIT;
`ifdef FIR_FEEDER_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end else begin
                    fir_in_valid_d = 1'b1;
                    fire_cnt_d     = fire_cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (fir_out_valid) begin
                    m_data_d  = fir_out;
                    m_valid_d = 1'b1;
                    state_d   = S_OUT;
                end
`ifdef FIR_FEEDER_TIMEOUT_EN
                else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            S_OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        s_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            s_ready_q      <= 1'b0;
            fir_wind_q     <= 1'b0;
            fir_load_q     <= 1'b0;
            fir_in_valid_q <= 1'b0;
            fir_data_q     <= '0;
            fire_cnt_q     <= '0;
            m_valid_q      <= 1'b0;
            m_data_q       <= '0;
        end else begin
            state_q        <= state_d;
            s_ready_q      <= s_ready_d;
            fir_wind_q     <= fir_wind_d;
            fir_load_q     <= fir_load_d;
            fir_in_valid_q <= fir_in_valid_d;
            fir_data_q     <= fir_data_d;
            fire_cnt_q     <= fire_cnt_d;
            m_valid_q      <= m_valid_d;
            m_data_q       <= m_data_d;
        end
    end

`ifdef FIR_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign s_ready      = s_ready_q;
    assign fir_wind     = fir_wind_q;
    assign fir_load     = fir_load_q;
    assign fir_in_valid = fir_in_valid_q;
    assign fir_data     = fir_data_q;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_feeder.sv
// ============================================================================
// Module   : tb_fir_feeder
// Brief    : Self-checking bench for fir_feeder with a behavioural filter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fir_feeder;

    localparam int TAPS        = 16;
    localparam int FIRE_CYCLES = 4;
    localparam int TIMEOUT     = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        s_is_coef = 1'b0;
    logic        fir_wind, fir_load, fir_in_valid;
    logic [15:0] fir_data;
    logic        fir_out_valid = 1'b0;
    logic [15:0] fir_out = '0;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready = 1'b0;
    logic        coef_ok, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fir_feeder #(.TAPS(TAPS), .FIRE_CYCLES(FIRE_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_is_coef(s_is_coef), .fir_wind(fir_wind), .fir_load(fir_load),
        .fir_in_valid(fir_in_valid), .fir_data(fir_data), .fir_out_valid(fir_out_valid),
        .fir_out(fir_out), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .coef_ok(coef_ok), .err(err)
    );

    // Behavioural filter: shift registers captured on the falling edge, one result per burst.
    logic [15:0] cw [TAPS];
    logic [15:0] sw [TAPS];
    bit  mute = 0;
    int  resp_delay = 0;
    bit  pend = 0;
    int  pend_cnt = 0;
    logic prev_iv = 1'b0;

    function automatic logic [15:0] filt_dot();
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < TAPS; i++) acc = acc + cw[i] * sw[i];
        return acc[15:0];
    endfunction

    always @(negedge clk) begin
        fir_out_valid = 1'b0;
        if (rst) begin
            pend    = 0;
            prev_iv = 1'b0;
        end else begin
            if (fir_wind) begin
                for (int i = TAPS - 1; i > 0; i--) cw[i] = cw[i-1];
                cw[0] = fir_data;
            end
            if (fir_load) begin
                for (int i = TAPS - 1; i > 0; i--) sw[i] = sw[i-1];
                sw[0] = fir_data;
            end
            if (prev_iv && !fir_in_valid && !mute) begin
                pend     = 1;
                pend_cnt = resp_delay;
            end
            prev_iv = fir_in_valid;
            if (pend) begin
                if (pend_cnt == 0) begin
                    fir_out_valid = 1'b1;
                    fir_out       = filt_dot();
                    pend          = 0;
                end else begin
                    pend_cnt--;
                end
            end
        end
    end

    // Activity monitor.
    int wind_n = 0, load_n = 0, burst_n = 0, last_len = 0, cur_len = 0, bad_start = 0, mv_n = 0;
    logic mon_iv = 1'b0, mon_ld = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            cur_len = 0;
            mon_iv  = 1'b0;
            mon_ld  = 1'b0;
        end else begin
            wind_n += int'(fir_wind);
            load_n += int'(fir_load);
            mv_n   += int'(m_valid);
            if (fir_in_valid) begin
                if (!mon_iv && !mon_ld) bad_start++;
                cur_len++;
            end else if (mon_iv) begin
                burst_n++;
                last_len = cur_len;
                cur_len  = 0;
            end
            mon_iv = fir_in_valid;
            mon_ld = fir_load;
        end
    end

    // Reference model: beat history since the last coefficient restart.
    logic [15:0] mc[$];
    logic [15:0] ms[$];
    logic [15:0] exp_q[$];

    function automatic bit model_beat(input logic [15:0] d, input bit c);
        logic [31:0] acc;
        acc = '0;
        if (c) begin
            if (mc.size() == TAPS) begin
                mc.delete();
                ms.delete();
            end
            mc.push_back(d);
            return 0;
        end
        ms.push_back(d);
        if (ms.size() > TAPS) void'(ms.pop_front());
        if (mc.size() != TAPS || ms.size() != TAPS) return 0;
        for (int i = 0; i < TAPS; i++) acc = acc + mc[i] * ms[i];
        exp_q.push_back(acc[15:0]);
        return 1;
    endfunction

    task automatic nedge();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        repeat (3) nedge();
        rst = 1'b0;
        mc.delete(); ms.delete(); exp_q.delete();
        nedge();
    endtask

    task automatic send_beat(input logic [15:0] d, input bit c, output bit fire);
        int n;
        n = 0;
        while (s_ready !== 1'b1 && n < 200) begin
            nedge();
            n++;
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_ready_wait: s_ready=%b required 1", s_ready);
        end
        s_valid = 1'b1; s_data = d; s_is_coef = c;
        nedge();
        s_valid = 1'b0;
        total++;
        if (fir_data !== d || fir_wind !== c || fir_load !== !c) begin
            bad++;
            $display("FAIL shift_outputs: data=%h wind=%b load=%b required data=%h wind=%b load=%b",
                     fir_data, fir_wind, fir_load, d, c, !c);
        end
        fire = model_beat(d, c);
    endtask

    task automatic take_result(input int hold, output logic [15:0] got);
        int n, mv0;
        bit stable;
        logic [15:0] exp;
        n = 0; stable = 1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        while (m_valid !== 1'b1 && n < 100) begin
            nedge();
            n++;
        end
        got = m_data;
        total++;
        if (m_valid !== 1'b1 || m_data !== exp) begin
            bad++;
            $display("FAIL result_data: m_valid=%b m_data=%0d required 1 %0d", m_valid, m_data, exp);
        end
        mv0 = mv_n;
        for (int i = 0; i < hold; i++) begin
            nedge();
            if (m_valid !== 1'b1 || m_data !== got) stable = 0;
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL result_hold: m_valid=%b m_data=%0d required 1 %0d", m_valid, m_data, got);
        end
        m_ready = 1'b1;
        nedge();
        m_ready = 1'b0;
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL result_release: m_valid=%b s_ready=%b required 0 1", m_valid, s_ready);
        end
        total++;
        if (mv_n - mv0 != hold) begin
            bad++;
            $display("FAIL result_valid_cycles: got %0d required %0d", mv_n - mv0 + 1, hold + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) nedge();
        total++;
        if ({s_ready, fir_wind, fir_load, fir_in_valid, fir_data, m_valid, m_data, coef_ok, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {s_ready, fir_wind, fir_load, fir_in_valid, fir_data, m_valid, m_data, coef_ok, err});
        end
        rst = 1'b0;
        #1;
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_early: s_ready=%b required 0", s_ready);
        end
        nedge();
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic test_coef_load();
        int w0;
        bit f;
        w0 = wind_n;
        for (int i = 0; i < TAPS; i++) begin
            send_beat(16'd1, 1'b1, f);
            if (i == TAPS - 2) begin
                total++;
                if (coef_ok !== 1'b0) begin
                    bad++;
                    $display("FAIL coef_ok_early: got %b required 0", coef_ok);
                end
            end
        end
        total++;
        if (coef_ok !== 1'b1 || wind_n - w0 != TAPS) begin
            bad++;
            $display("FAIL coef_load: coef_ok=%b winds=%0d required 1 %0d", coef_ok, wind_n - w0, TAPS);
        end
    endtask

    task automatic test_window_fill();
        int b0;
        bit f;
        logic [15:0] got;
        b0 = burst_n;
        for (int v = 1; v <= TAPS; v++) send_beat(16'(v), 1'b0, f);
        total++;
        if (fir_in_valid !== 1'b0) begin
            bad++;
            $display("FAIL fire_start_early: fir_in_valid=%b required 0", fir_in_valid);
        end
        nedge();
        total++;
        if (fir_in_valid !== 1'b1) begin
            bad++;
            $display("FAIL fire_start: fir_in_valid=%b required 1", fir_in_valid);
        end
        take_result(0, got);
        total++;
        if (got !== 16'd136 || burst_n - b0 != 1 || last_len != FIRE_CYCLES || bad_start != 0) begin
            bad++;
            $display("FAIL window_fill: m_data=%0d bursts=%0d len=%0d bad_start=%0d required 136 1 %0d 0",
                     got, burst_n - b0, last_len, bad_start, FIRE_CYCLES);
        end
    endtask

    task automatic test_hold();
        bit f;
        logic [15:0] got;
        send_beat(16'd17, 1'b0, f);
        take_result(10, got);
        total++;
        if (got !== 16'd152) begin
            bad++;
            $display("FAIL hold_value: m_data=%0d required 152", got);
        end
    endtask

    task automatic test_ready_high();
        bit f;
        logic [15:0] got;
        m_ready = 1'b1;
        send_beat(16'd18, 1'b0, f);
        take_result(0, got);
        total++;
        if (got !== 16'd168) begin
            bad++;
            $display("FAIL ready_high_value: m_data=%0d required 168", got);
        end
    endtask

    task automatic test_restart();
        int b0, m0;
        bit f;
        logic [15:0] got;
        send_beat(16'($urandom), 1'b1, f);
        total++;
        if (coef_ok !== 1'b0) begin
            bad++;
            $display("FAIL restart_coef_ok: got %b required 0", coef_ok);
        end
        for (int i = 1; i < TAPS; i++) send_beat(16'($urandom), 1'b1, f);
        b0 = burst_n; m0 = mv_n;
        for (int i = 0; i < TAPS - 1; i++) send_beat(16'($urandom), 1'b0, f);
        nedge();
        total++;
        if (burst_n != b0 || mv_n != m0) begin
            bad++;
            $display("FAIL restart_no_result: bursts=%0d results=%0d required 0 0", burst_n - b0, mv_n - m0);
        end
        send_beat(16'($urandom), 1'b0, f);
        if (f) take_result(1, got);
    endtask

    task automatic test_random();
        bit f;
        int ns;
        logic [15:0] got;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < TAPS; i++) send_beat(16'($urandom), 1'b1, f);
            ns = TAPS + $urandom_range(0, 6);
            for (int i = 0; i < ns; i++) begin
                resp_delay = $urandom_range(0, 5);
                m_ready = 1'($urandom_range(0, 1));
                send_beat(16'($urandom), 1'b0, f);
                if (f) take_result(m_ready ? 0 : $urandom_range(0, 3), got);
                m_ready = 1'b0;
            end
        end
        resp_delay = 0;
    endtask

    task automatic test_timeout();
        bit f;
        int n;
        mute = 1;
        send_beat(16'($urandom), 1'b0, f);
        if (f) void'(exp_q.pop_front());
        n = 0;
        while (fir_in_valid !== 1'b1 && n < 20) begin nedge(); n++; end
        while (fir_in_valid !== 1'b0 && n < 40) begin nedge(); n++; end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL timeout_burst: fir_in_valid=%b required 0", fir_in_valid);
        end
`ifdef FIR_FEEDER_TIMEOUT_EN
        for (int k = 1; k <= TIMEOUT; k++) begin
            nedge();
            if (k == TIMEOUT - 1) begin
                total++;
                if (err !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_early: err=%b required 0", err);
                end
            end
        end
        total++;
        if (err !== 1'b1 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err: err=%b s_ready=%b m_valid=%b required 1 1 0", err, s_ready, m_valid);
        end
`else
        repeat (TIMEOUT + 8) nedge();
        total++;
        if (err !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL wait_persist: err=%b s_ready=%b m_valid=%b required 0 0 0", err, s_ready, m_valid);
        end
`endif
        mute = 0;
        do_reset();
        total++;
        if (err !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_recover: err=%b s_ready=%b required 0 1", err, s_ready);
        end
    endtask

    task automatic test_reset_midburst();
        bit f;
        int b0, m0;
        for (int i = 0; i < TAPS; i++) send_beat(16'($urandom), 1'b1, f);
        for (int i = 0; i < TAPS; i++) send_beat(16'($urandom), 1'b0, f);
        if (f) void'(exp_q.pop_front());
        nedge();
        nedge();
        total++;
        if (fir_in_valid !== 1'b1) begin
            bad++;
            $display("FAIL midburst_fire: fir_in_valid=%b required 1", fir_in_valid);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({s_ready, fir_wind, fir_load, fir_in_valid, fir_data, m_valid, m_data, coef_ok, err} !== '0) begin
            bad++;
            $display("FAIL midburst_reset: got %h required 0",
                     {s_ready, fir_wind, fir_load, fir_in_valid, fir_data, m_valid, m_data, coef_ok, err});
        end
        repeat (2) nedge();
        rst = 1'b0;
        mc.delete(); ms.delete(); exp_q.delete();
        b0 = burst_n; m0 = mv_n;
        repeat (40) nedge();
        total++;
        if (mv_n != m0 || burst_n != b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL midburst_after: results=%0d bursts=%0d s_ready=%b required 0 0 1",
                     mv_n - m0, burst_n - b0, s_ready);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_coef_load();
        test_window_fill();
        test_hold();
        test_ready_high();
        test_restart();
        test_random();
        test_timeout();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
